// File: rtl/rf_pkg.sv
// Shared definitions for the register file slice.
// Holds the default geometry, the address-width helper and the
// default address/data typedefs used by the register file and its users.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Address width for a given register count; never below one bit.
    function automatic int rf_aw(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

    localparam int AW_DEF = rf_aw(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   rf_addr_t;
    typedef logic [XLEN_DEF-1:0] rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for the register file.
// Tracks one busy bit per register: set by an accepted reservation, cleared
// by a write to that register, all cleared by flush. Reports whether a
// reservation can be accepted and keeps a running count of busy registers.
//   clk, rst_n  : clock, async active-low reset
//   rsv_valid   : reservation request for rsv_addr
//   rsv_addr    : register being reserved
//   wr_hit      : per-register "written this cycle" (already zero-reg filtered)
//   flush       : clear all busy bits at the edge
//   busy        : current busy vector
//   rsv_ready   : reservation accepted this cycle
//   busy_cnt    : number of busy registers
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW      = rf_aw(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [NREGS-1:0] wr_hit,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic             rsv_ready,
    output logic [AW:0]      busy_cnt
);

    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      n_set;
    logic [AW:0]      n_clr;
    logic             set_r;

    // A register being written this cycle frees up its slot for a new producer.
    assign rsv_ready = ~busy[rsv_addr] | wr_hit[rsv_addr];

    always_comb begin
        busy_nxt = busy;
        n_set    = '0;
        n_clr    = '0;
        set_r    = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            set_r = rsv_valid && rsv_ready && (rsv_addr == AW'(r))
                    && !((ZERO_REG != 0) && (r == 0));
            // Reserve beats a same-cycle write; flush beats everything.
            if (flush)
                busy_nxt[r] = 1'b0;
            else if (set_r)
                busy_nxt[r] = 1'b1;
            else if (wr_hit[r])
                busy_nxt[r] = 1'b0;
            if (busy_nxt[r] && !busy[r])
                n_set = n_set + (AW+1)'(1);
            if (!busy_nxt[r] && busy[r])
                n_clr = n_clr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt + n_set - n_clr;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write-first bypass and busy scoreboard.
//   clk, rst_n          : clock, async active-low reset
//   ra / rd / rd_busy   : NRD combinational read ports (data and busy bit)
//   we / wa / wd        : NWR synchronous write ports, higher index wins
//   rsv_valid/rsv_addr  : reserve a register (mark busy)
//   rsv_ready           : reservation accepted this cycle
//   flush               : clear all busy bits
//   busy_cnt            : number of busy registers
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = rf_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ready,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NWR-1:0]   we_eff;
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] busy;
    logic [AW-1:0]    rd_addr;
    logic [XLEN-1:0]  rd_data;

    // Writes to the hardwired zero register are dropped here, so they neither
    // store, bypass, nor clear a busy bit anywhere downstream.
    always_comb begin
        we_eff = '0;
        wr_hit = '0;
        for (int p = 0; p < NWR; p++) begin
            we_eff[p] = we[p] && !((ZERO_REG != 0) && (wa[p*AW +: AW] == '0));
            if (we_eff[p])
                wr_hit[wa[p*AW +: AW]] = 1'b1;
        end
    end

    // Later ports are applied last, so the highest-index port wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++)
                mem[r] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++)
                if (we_eff[p])
                    mem[wa[p*AW +: AW]] <= wd[p*XLEN +: XLEN];
        end
    end

    always_comb begin
        rd      = '0;
        rd_busy = '0;
        rd_addr = '0;
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_addr = ra[i*AW +: AW];
            rd_data = mem[rd_addr];
            for (int p = 0; p < NWR; p++)
                if (we_eff[p] && (wa[p*AW +: AW] == rd_addr))
                    rd_data = wd[p*XLEN +: XLEN];
            rd[i*XLEN +: XLEN] = rd_data;
            rd_busy[i]         = busy[rd_addr] & ~wr_hit[rd_addr];
        end
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .wr_hit    (wr_hit),
        .flush     (flush),
        .busy      (busy),
        .rsv_ready (rsv_ready),
        .busy_cnt  (busy_cnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rd_busy;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rsv_ready;
    logic        flush;
    logic [5:0]  busy_cnt;

    int          n_vec  = 0;
    int          n_fail = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    reg_file_sb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra        (ra),
        .rd        (rd),
        .rd_busy   (rd_busy),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .flush     (flush),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1);
    end

    task automatic push(input string t, input logic [31:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL queue_underflow: observed %h required none", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    task automatic idle();
        we = 2'b00; wa = '0; wd = '0;
        rsv_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_ports(input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
        push("rd0", e0); push("rd1", e1); push("rd_busy", {30'b0, eb});
        #1;
        pop_chk(rd[31:0]); pop_chk(rd[63:32]); pop_chk({30'b0, rd_busy});
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        ra = '0; rsv_addr = '0;
        #12 rst_n = 1'b1;
        tick();

        // reset state
        rsv_addr = 5'd3;
        push("cnt_rst", 32'd0); push("rdy_rst", 32'd1);
        #1;
        pop_chk({26'b0, busy_cnt}); pop_chk({31'b0, rsv_ready});
        for (int r = 1; r < 32; r++) begin
            ra = {5'(r), 5'(r)};
            rd_ports(32'h0, 32'h0, 2'b00);
        end
        tick();

        // single write with same-cycle bypass, then from storage
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEADBEEF}; ra = {5'd1, 5'd5};
        rd_ports(32'hDEADBEEF, 32'h0, 2'b00);
        tick(); idle();
        ra = {5'd5, 5'd5};
        rd_ports(32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
        tick();

        // both ports write x7: port 1 wins
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22222222, 32'h11111111}; ra = {5'd7, 5'd7};
        rd_ports(32'h22222222, 32'h22222222, 2'b00);
        tick(); idle();
        rd_ports(32'h22222222, 32'h22222222, 2'b00);
        tick();

        // distinct addresses on both ports at once
        we = 2'b11; wa = {5'd12, 5'd11}; wd = {32'hCAFE0012, 32'hCAFE0011}; ra = {5'd11, 5'd12};
        rd_ports(32'hCAFE0012, 32'hCAFE0011, 2'b00);
        tick(); idle();
        rd_ports(32'hCAFE0012, 32'hCAFE0011, 2'b00);
        tick();

        // write to x0 is discarded, no bypass
        we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'h0, 32'hFFFFFFFF}; ra = {5'd0, 5'd0};
        rd_ports(32'h0, 32'h0, 2'b00);
        tick(); idle();
        rd_ports(32'h0, 32'h0, 2'b00);
        tick();

        // reserve x3
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        push("rdy_x3_free", 32'd1); #1; pop_chk({31'b0, rsv_ready});
        tick(); idle();
        ra = {5'd3, 5'd3};
        push("cnt_x3", 32'd1); #1; pop_chk({26'b0, busy_cnt});
        rd_ports(32'h0, 32'h0, 2'b11);
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        push("rdy_x3_waw", 32'd0); #1; pop_chk({31'b0, rsv_ready});
        tick(); idle();
        push("cnt_x3_rej", 32'd1); #1; pop_chk({26'b0, busy_cnt});
        // write x3 clears busy, bypass not reported busy
        we = 2'b10; wa = {5'd3, 5'd0}; wd = {32'h42, 32'h0}; rsv_addr = 5'd3;
        push("rdy_x3_wr", 32'd1); #1; pop_chk({31'b0, rsv_ready});
        rd_ports(32'h42, 32'h42, 2'b00);
        tick(); idle();
        push("cnt_x3_clr", 32'd0); #1; pop_chk({26'b0, busy_cnt});
        rd_ports(32'h42, 32'h42, 2'b00);
        tick();

        // same-cycle reserve and write of x9: reserve wins
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h99};
        tick(); idle();
        ra = {5'd9, 5'd9};
        push("cnt_x9", 32'd1); #1; pop_chk({26'b0, busy_cnt});
        rd_ports(32'h99, 32'h99, 2'b11);
        // flush beats a same-cycle reserve of x10, contents kept
        flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 5'd10;
        tick(); idle();
        ra = {5'd10, 5'd9};
        push("cnt_flush", 32'd0); #1; pop_chk({26'b0, busy_cnt});
        rd_ports(32'h99, 32'h0, 2'b00);
        // reserve of x0 accepted, sets nothing
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        push("rdy_x0", 32'd1); #1; pop_chk({31'b0, rsv_ready});
        tick(); idle();
        ra = {5'd0, 5'd0};
        push("cnt_x0", 32'd0); #1; pop_chk({26'b0, busy_cnt});
        rd_ports(32'h0, 32'h0, 2'b00);

        // reserve x2, x4, x6
        for (int k = 1; k <= 3; k++) begin
            rsv_valid = 1'b1; rsv_addr = 5'(2 * k);
            tick();
        end
        idle();
        push("cnt_three", 32'd3); #1; pop_chk({26'b0, busy_cnt});
        ra = {5'd4, 5'd2};
        rd_ports(32'h0, 32'h0, 2'b11);

        // async reset between edges
        ra = {5'd7, 5'd5}; rsv_addr = 5'd2;
        #1 rst_n = 1'b0;
        push("cnt_arst", 32'd0); push("rdy_arst", 32'd1);
        #1;
        pop_chk({26'b0, busy_cnt}); pop_chk({31'b0, rsv_ready});
        rd_ports(32'h0, 32'h0, 2'b00);
        // a write held across an edge during reset is lost
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'h55};
        tick();
        idle();
        rst_n = 1'b1;
        ra = {5'd5, 5'd4};
        rd_ports(32'h0, 32'h0, 2'b00);
        push("cnt_post", 32'd0); #1; pop_chk({26'b0, busy_cnt});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
